traffic_light_monitor: RTL and testbench

- Passive checker on the six lamp outputs of the traffic light controller. It is the consumer end of that lamp interface.
- Decodes lamp patterns into phases and enforces legal patterns, legal phase order and exact dwell times.
- Reports sticky and pulsed errors, an error count, a lock indication and a completed-cycle count.
- Sits beside the controller in benches and in silicon as a safety watchdog.

---
 rtl/traffic_light_monitor.sv | 166 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive watchdog on the six traffic-light lamps: pattern, order and dwell checks.
// Define TLM_DWELL_CHECK_EN to add the dwell counter and the short/long dwell checks.
module traffic_light_monitor #(
    parameter int GREEN_CYCLES  = 11,
    parameter int YELLOW_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NS_red,
    input  logic             NS_yellow,
    input  logic             NS_green,
    input  logic             EW_red,
    input  logic             EW_yellow,
    input  logic             EW_green,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic             locked,
    output logic [CNT_W-1:0] cycles_done
);

    typedef enum logic [2:0] {
        SYNC,
        NSG,
        NSY,
        EWG,
        EWY
    } state_t;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_ILLEGAL = 3'd1;
    localparam logic [2:0] E_SEQ     = 3'd2;
`ifdef TLM_DWELL_CHECK_EN
    localparam logic [2:0] E_SHORT   = 3'd3;
    localparam logic [2:0] E_LONG    = 3'd4;
`endif

    if (GREEN_CYCLES >= (1 << CNT_W) - 1 ||
        YELLOW_CYCLES >= (1 << CNT_W) - 1) begin : g_bad_cfg
        $error("dwell requirement does not fit in CNT_W");
    end

    state_t state;
    state_t pat;
    state_t succ;
    logic   legal;
    logic [2:0] code;

`ifdef TLM_DWELL_CHECK_EN
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] need;
    logic             first;
`endif

    always_comb begin
        legal = 1'b1;
        pat   = SYNC;
        case ({NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green})
            6'b001_100: pat = NSG;
            6'b010_100: pat = NSY;
            6'b100_001: pat = EWG;
            6'b100_010: pat = EWY;
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        case (state)
            NSG:     succ = NSY;
            NSY:     succ = EWG;
            EWG:     succ = EWY;
            EWY:     succ = NSG;
            default: succ = SYNC;
        endcase
    end

`ifdef TLM_DWELL_CHECK_EN
    always_comb begin
        if (state == NSG || state == EWG) begin
            need = CNT_W'(GREEN_CYCLES);
        end else begin
            need = CNT_W'(YELLOW_CYCLES);
        end
    end
`endif

    // Priority chain: only the most severe violation is reported per sample.
    always_comb begin
        code = E_NONE;
        if (state != SYNC) begin
            if (!legal) begin
                code = E_ILLEGAL;
            end else if (pat != state && pat != succ) begin
                code = E_SEQ;
            end
`ifdef TLM_DWELL_CHECK_EN
            else if (pat == succ && dwell < need && !first) begin
                code = E_SHORT;
            end else if (pat == state && dwell == need) begin
                code = E_LONG;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            err         <= 1'b0;
            err_code    <= E_NONE;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            locked      <= 1'b0;
            cycles_done <= '0;
`ifdef TLM_DWELL_CHECK_EN
            dwell       <= '0;
            first       <= 1'b0;
`endif
        end else begin
            err_pulse <= 1'b0;
            if (code != E_NONE) begin
                err_pulse <= 1'b1;
                err       <= 1'b1;
                if (!err) begin
                    err_code <= code;
                end
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                locked <= 1'b0;
                state  <= SYNC;
`ifdef TLM_DWELL_CHECK_EN
                dwell  <= '0;
                first  <= 1'b0;
`endif
            end else if (state == SYNC) begin
                if (legal) begin
                    state <= pat;
`ifdef TLM_DWELL_CHECK_EN
                    dwell <= CNT_W'(1);
                    first <= 1'b1;
`endif
                end
            end else if (pat != state) begin
                // No error and not the same pattern: this is the successor.
                state  <= succ;
                locked <= 1'b1;
                if (state == EWY) begin
                    cycles_done <= cycles_done + 1'b1;
                end
`ifdef TLM_DWELL_CHECK_EN
                dwell  <= CNT_W'(1);
                first  <= 1'b0;
`endif
            end
`ifdef TLM_DWELL_CHECK_EN
            else begin
                dwell <= dwell + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus a randomized lamp walk
// checked against a phase-level reference model.
module tb_traffic_light_monitor;

    localparam int GREEN  = 11;
    localparam int YELLOW = 4;

`ifdef TLM_DWELL_CHECK_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] lamps = 6'b000_000;
    logic       err;
    logic [2:0] err_code;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       locked;
    logic [7:0] cycles_done;

    int vectors = 0;
    int miscompares = 0;

    // Legal patterns indexed by phase: 0 NSG, 1 NSY, 2 EWG, 3 EWY.
    logic [5:0] pats [4] = '{6'b001_100, 6'b010_100, 6'b100_001, 6'b100_010};
    logic [5:0] ILL = 6'b001_001;

    int         m_phase;
    int         m_hold;
    bit         m_first;
    bit         m_err;
    logic [2:0] m_code;
    bit         m_pulse;
    logic [7:0] m_cnt;
    bit         m_locked;
    logic [7:0] m_cycles;

    traffic_light_monitor #(
        .GREEN_CYCLES(GREEN),
        .YELLOW_CYCLES(YELLOW),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .NS_red(lamps[5]),
        .NS_yellow(lamps[4]),
        .NS_green(lamps[3]),
        .EW_red(lamps[2]),
        .EW_yellow(lamps[1]),
        .EW_green(lamps[0]),
        .err(err),
        .err_code(err_code),
        .err_pulse(err_pulse),
        .err_cnt(err_cnt),
        .locked(locked),
        .cycles_done(cycles_done)
    );

    always #5 clk = ~clk;

    function automatic int need_of(input int p);
        return (p % 2 == 0) ? GREEN : YELLOW;
    endfunction

    function automatic int decode(input logic [5:0] l);
        for (int i = 0; i < 4; i++) begin
            if (pats[i] == l) return i;
        end
        return -1;
    endfunction

    function automatic logic [21:0] dut_bus();
        return {err, err_code, err_pulse, err_cnt, locked, cycles_done};
    endfunction

    function automatic logic [21:0] model_bus();
        return {m_err, m_code, m_pulse, m_cnt, m_locked, m_cycles};
    endfunction

    task automatic model_step(input logic [5:0] l, input bit r);
        int p;
        int nxt;
        logic [2:0] c;
        if (r) begin
            m_phase = -1; m_hold = 0; m_first = 0;
            m_err = 0; m_code = 0; m_pulse = 0;
            m_cnt = 0; m_locked = 0; m_cycles = 0;
            return;
        end
        p = decode(l);
        m_pulse = 0;
        if (m_phase < 0) begin
            if (p >= 0) begin
                m_phase = p; m_hold = 1; m_first = 1;
            end
            return;
        end
        nxt = (m_phase + 1) % 4;
        c = 0;
        if (p < 0) c = 1;
        else if (p != m_phase && p != nxt) c = 2;
        else if (DWELL_EN && p == nxt && m_hold < need_of(m_phase) && !m_first) c = 3;
        else if (DWELL_EN && p == m_phase && m_hold == need_of(m_phase)) c = 4;
        if (c != 0) begin
            m_pulse = 1;
            if (m_cnt != 8'hff) m_cnt++;
            if (!m_err) m_code = c;
            m_err = 1;
            m_locked = 0;
            m_phase = -1;
        end else if (p == m_phase) begin
            m_hold++;
        end else begin
            if (m_phase == 3) m_cycles++;
            m_phase = p; m_hold = 1; m_first = 0; m_locked = 1;
        end
    endtask

    task automatic apply(input logic [5:0] l, input bit r);
        @(negedge clk);
        lamps = l;
        rst = r;
        @(posedge clk);
        model_step(l, r);
        #1;
    endtask

    task automatic test_reset();
        apply(ILL, 1'b1);
        apply(pats[0], 1'b1);
        vectors++;
        if (dut_bus() !== 22'd0) begin
            miscompares++;
            $display("FAIL reset: dut=%h expected=%h", dut_bus(), 22'd0);
        end
        apply(ILL, 1'b0);
        vectors++;
        if (dut_bus() !== model_bus() || err !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_illegal: dut=%h model=%h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_ideal();
        apply(ILL, 1'b1);
        for (int c = 0; c < 3; c++) begin
            for (int ph = 0; ph < 4; ph++) begin
                for (int k = 0; k < need_of(ph); k++) begin
                    apply(pats[ph], 1'b0);
                    vectors++;
                    if (dut_bus() !== model_bus()) begin
                        miscompares++;
                        $display("FAIL ideal c%0d p%0d: dut=%h model=%h",
                                 c, ph, dut_bus(), model_bus());
                    end
                    if (c == 0 && ph == 1 && k == 0) begin
                        vectors++;
                        if (locked !== 1'b1) begin
                            miscompares++;
                            $display("FAIL ideal_lock: locked=%b expected=1", locked);
                        end
                    end
                end
            end
        end
        apply(pats[0], 1'b0);
        vectors++;
        if ({err, err_cnt, locked, cycles_done} !== {1'b0, 8'd0, 1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL ideal_end: err=%b cnt=%0d locked=%b cycles=%0d expected 0 0 1 3",
                     err, err_cnt, locked, cycles_done);
        end
    endtask

    task automatic test_illegal();
        apply(ILL, 1'b1);
        for (int k = 0; k < 5; k++) apply(pats[0], 1'b0);
        apply(ILL, 1'b0);
        vectors++;
        if ({err_pulse, err, err_code, err_cnt, locked} !== {1'b1, 1'b1, 3'd1, 8'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal: pulse=%b err=%b code=%0d cnt=%0d locked=%b expected 1 1 1 1 0",
                     err_pulse, err, err_code, err_cnt, locked);
        end
        apply(pats[0], 1'b0);
        vectors++;
        if (err_pulse !== 1'b0 || dut_bus() !== model_bus()) begin
            miscompares++;
            $display("FAIL illegal_pulse_once: dut=%h model=%h", dut_bus(), model_bus());
        end
        apply(pats[1], 1'b0);
        vectors++;
        if (locked !== 1'b1 || dut_bus() !== model_bus()) begin
            miscompares++;
            $display("FAIL relock: locked=%b dut=%h model=%h", locked, dut_bus(), model_bus());
        end
    endtask

    task automatic test_bad_seq();
        apply(ILL, 1'b1);
        for (int k = 0; k < GREEN; k++) apply(pats[0], 1'b0);
        apply(pats[2], 1'b0);
        vectors++;
        if ({err, err_code, err_cnt} !== {1'b1, 3'd2, 8'd1}) begin
            miscompares++;
            $display("FAIL bad_seq: err=%b code=%0d cnt=%0d expected 1 2 1",
                     err, err_code, err_cnt);
        end
    endtask

    task automatic test_short_dwell();
        apply(ILL, 1'b1);
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < need_of(ph); k++) apply(pats[ph], 1'b0);
        end
        for (int k = 0; k < GREEN; k++) apply(pats[0], 1'b0);
        apply(pats[1], 1'b0);
        apply(pats[1], 1'b0);
        apply(pats[2], 1'b0);
        vectors++;
        if (DWELL_EN && {err, err_code, err_pulse} !== {1'b1, 3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL short_dwell: err=%b code=%0d pulse=%b expected 1 3 1",
                     err, err_code, err_pulse);
        end else if (!DWELL_EN && err !== 1'b0) begin
            miscompares++;
            $display("FAIL short_dwell_off: err=%b expected 0", err);
        end
    endtask

    task automatic test_long_dwell();
        apply(ILL, 1'b1);
        apply(pats[3], 1'b0);
        for (int k = 1; k <= 12; k++) begin
            apply(pats[0], 1'b0);
            vectors++;
            if (err_pulse !== (DWELL_EN && k == 12)) begin
                miscompares++;
                $display("FAIL long_dwell k%0d: pulse=%b expected=%b",
                         k, err_pulse, (DWELL_EN && k == 12));
            end
        end
        vectors++;
        if (err_code !== (DWELL_EN ? 3'd4 : 3'd0) || cycles_done !== 8'd1) begin
            miscompares++;
            $display("FAIL long_dwell_code: code=%0d cycles=%0d expected %0d 1",
                     err_code, cycles_done, DWELL_EN ? 4 : 0);
        end
    endtask

    task automatic test_sticky();
        apply(ILL, 1'b1);
        for (int k = 0; k < GREEN; k++) apply(pats[0], 1'b0);
        apply(pats[2], 1'b0);
        apply(pats[2], 1'b0);
        apply(ILL, 1'b0);
        vectors++;
        if ({err, err_code, err_pulse, err_cnt} !== {1'b1, 3'd2, 1'b1, 8'd2}) begin
            miscompares++;
            $display("FAIL sticky: err=%b code=%0d pulse=%b cnt=%0d expected 1 2 1 2",
                     err, err_code, err_pulse, err_cnt);
        end
        apply(pats[0], 1'b0);
        apply(pats[0], 1'b0);
        apply(pats[0], 1'b1);
        vectors++;
        if (dut_bus() !== 22'd0) begin
            miscompares++;
            $display("FAIL mid_reset: dut=%h expected=%h", dut_bus(), 22'd0);
        end
        apply(pats[2], 1'b0);
        vectors++;
        if ({err, locked, err_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL post_reset_sync: err=%b locked=%b cnt=%0d expected 0 0 0",
                     err, locked, err_cnt);
        end
    endtask

    task automatic test_random();
        int g = 0;
        int rem = GREEN;
        int r;
        apply(ILL, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 4) begin
                apply(6'($urandom), 1'b1);
            end else if (r < 25) begin
                apply(6'($urandom), 1'b0);
            end else if (r < 40) begin
                apply(pats[$urandom_range(0, 3)], 1'b0);
            end else begin
                apply(pats[g], 1'b0);
                rem--;
                if (rem <= 0) begin
                    g = (g + 1) % 4;
                    rem = need_of(g);
                    if ($urandom_range(0, 9) >= 7) rem += int'($urandom_range(0, 3)) - 2;
                    if (rem < 1) rem = 1;
                end
            end
            vectors++;
            if (dut_bus() !== model_bus()) begin
                miscompares++;
                $display("FAIL random i%0d lamps=%b: dut=%h model=%h",
                         i, lamps, dut_bus(), model_bus());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_illegal();
        test_bad_seq();
        test_short_dwell();
        test_long_dwell();
        test_sticky();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
